// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encoding and byte-lane constants for the MEM pipeline stage.
package mem_access_stage_pkg;

   localparam int WORD_WIDTH           = 32;
   localparam int REGISTER_INDEX_WIDTH = 5;
   localparam int BYTE_WIDTH           = 8;
   localparam int LANE_COUNT           = WORD_WIDTH / BYTE_WIDTH;

   localparam logic [1:0] LANE_0 = 2'd0;
   localparam logic [1:0] LANE_1 = 2'd1;
   localparam logic [1:0] LANE_2 = 2'd2;
   localparam logic [1:0] LANE_3 = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte lane (little-endian) and
// sign-extends it for byte loads; word loads pass straight through.
module mem_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] rdata,
   input  logic [1:0]            lane,
   input  logic                  byte_access,
   output logic [WORD_WIDTH-1:0] load_data
);

   logic [BYTE_WIDTH-1:0] selected_byte;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      selected_byte = rdata[0 +: BYTE_WIDTH];
      load_data     = rdata;
      case (lane)
         LANE_0: selected_byte = rdata[0             +: BYTE_WIDTH];
         LANE_1: selected_byte = rdata[BYTE_WIDTH    +: BYTE_WIDTH];
         LANE_2: selected_byte = rdata[2*BYTE_WIDTH  +: BYTE_WIDTH];
         LANE_3: selected_byte = rdata[3*BYTE_WIDTH  +: BYTE_WIDTH];
      endcase
      if (byte_access) begin
         load_data = {{(WORD_WIDTH-BYTE_WIDTH){selected_byte[BYTE_WIDTH-1]}}, selected_byte};
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to the data cache over req/ready and stalls
// upstream until done. Optional misaligned-word trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            valid_in,
   input  logic                            cu_mem_read_in,
   input  logic                            cu_mem_write_in,
   input  logic                            cu_byte_in,
   input  logic [WORD_WIDTH-1:0]           alu_result_in,
   input  logic [WORD_WIDTH-1:0]           store_data_in,
   input  logic                            cu_mem_to_reg_in,
   input  logic                            cu_reg_write_in,
   input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
   output logic                            dc_req_out,
   output logic                            dc_we_out,
   output logic                            dc_byte_out,
   output logic [WORD_WIDTH-1:0]           dc_addr_out,
   output logic [WORD_WIDTH-1:0]           dc_wdata_out,
   input  logic                            dc_ready_in,
   input  logic [WORD_WIDTH-1:0]           dc_rdata_in,
   output logic                            stall_out,
   output logic                            valid_out,
   output logic [WORD_WIDTH-1:0]           mem_data_out,
   output logic [WORD_WIDTH-1:0]           alu_result_out,
   output logic                            cu_mem_to_reg_out,
   output logic                            cu_reg_write_out,
   output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
   output logic                            exc_misaligned_out
);

   state_e                          state_q, state_d;
   logic                            mem_op, misaligned;
   logic [WORD_WIDTH-1:0]           addr_q, wdata_q, load_data;
   logic                            we_q, byte_q, load_q, mem_to_reg_q, reg_write_q, exc_q;
   logic [REGISTER_INDEX_WIDTH-1:0] rd_q;

   assign mem_op = cu_mem_read_in | cu_mem_write_in;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misaligned = ~cu_byte_in & (alu_result_in[1:0] != LANE_0);
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so all flops update together.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_in && mem_op) state_d = misaligned ? RESP : ACCESS;
         ACCESS:  if (dc_ready_in)        state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall is raised in the presenting IDLE cycle so upstream holds the memory op.
   always_comb begin
      dc_req_out = 1'b0;
      stall_out  = 1'b0;
      case (state_q)
         IDLE:    stall_out = rst_n & valid_in & mem_op;
         ACCESS:  begin
            dc_req_out = 1'b1;
            stall_out  = 1'b1;
         end
         default: ;
      endcase
   end

   assign dc_addr_out        = addr_q;
   assign dc_wdata_out       = wdata_q;
   assign dc_we_out          = we_q;
   assign dc_byte_out        = byte_q;
   assign exc_misaligned_out = exc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         byte_q       <= 1'b0;
         load_q       <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
      end else if (state_q == IDLE && valid_in && mem_op) begin
         addr_q       <= alu_result_in;
         wdata_q      <= cu_byte_in ? {LANE_COUNT{store_data_in[BYTE_WIDTH-1:0]}} : store_data_in;
         we_q         <= cu_mem_write_in;
         byte_q       <= cu_byte_in;
         load_q       <= cu_mem_read_in & ~cu_mem_write_in;
         mem_to_reg_q <= cu_mem_to_reg_in;
         reg_write_q  <= cu_reg_write_in;
         rd_q         <= destination_register_in;
      end
   end

   mem_load_align u_load_align (
      .rdata       (dc_rdata_in),
      .lane        (addr_q[1:0]),
      .byte_access (byte_q),
      .load_data   (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out                <= 1'b0;
         mem_data_out             <= '0;
         alu_result_out           <= '0;
         cu_mem_to_reg_out        <= 1'b0;
         cu_reg_write_out         <= 1'b0;
         destination_register_out <= '0;
         exc_q                    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_out        <= 1'b0;
               cu_reg_write_out <= 1'b0;
               exc_q            <= 1'b0;
               // Non-memory ops and trapped accesses complete without touching the cache.
               if (valid_in && (!mem_op || misaligned)) begin
                  valid_out                <= 1'b1;
                  mem_data_out             <= '0;
                  alu_result_out           <= alu_result_in;
                  cu_mem_to_reg_out        <= cu_mem_to_reg_in;
                  cu_reg_write_out         <= cu_reg_write_in & ~misaligned;
                  destination_register_out <= destination_register_in;
                  exc_q                    <= misaligned;
               end
            end
            ACCESS: begin
               if (dc_ready_in) begin
                  valid_out                <= 1'b1;
                  mem_data_out             <= load_q ? load_data : '0;
                  alu_result_out           <= addr_q;
                  cu_mem_to_reg_out        <= mem_to_reg_q;
                  cu_reg_write_out         <= reg_write_q;
                  destination_register_out <= rd_q;
               end
            end
            default: begin
               valid_out        <= 1'b0;
               cu_reg_write_out <= 1'b0;
               exc_q            <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level reference model with a
// word-addressed memory, a randomized-latency cache responder and directed cases.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic                            clk, rst_n;
   logic                            valid_in, cu_mem_read_in, cu_mem_write_in, cu_byte_in;
   logic [WORD_WIDTH-1:0]           alu_result_in, store_data_in;
   logic                            cu_mem_to_reg_in, cu_reg_write_in;
   logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in;
   logic                            dc_req_out, dc_we_out, dc_byte_out;
   logic [WORD_WIDTH-1:0]           dc_addr_out, dc_wdata_out;
   logic                            dc_ready_in;
   logic [WORD_WIDTH-1:0]           dc_rdata_in;
   logic                            stall_out, valid_out;
   logic [WORD_WIDTH-1:0]           mem_data_out, alu_result_out;
   logic                            cu_mem_to_reg_out, cu_reg_write_out;
   logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out;
   logic                            exc_misaligned_out;

   mem_access_stage dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
      .cu_mem_read_in(cu_mem_read_in), .cu_mem_write_in(cu_mem_write_in), .cu_byte_in(cu_byte_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .cu_mem_to_reg_in(cu_mem_to_reg_in), .cu_reg_write_in(cu_reg_write_in),
      .destination_register_in(destination_register_in),
      .dc_req_out(dc_req_out), .dc_we_out(dc_we_out), .dc_byte_out(dc_byte_out),
      .dc_addr_out(dc_addr_out), .dc_wdata_out(dc_wdata_out),
      .dc_ready_in(dc_ready_in), .dc_rdata_in(dc_rdata_in),
      .stall_out(stall_out), .valid_out(valid_out), .mem_data_out(mem_data_out),
      .alu_result_out(alu_result_out), .cu_mem_to_reg_out(cu_mem_to_reg_out),
      .cu_reg_write_out(cu_reg_write_out), .destination_register_out(destination_register_out),
      .exc_misaligned_out(exc_misaligned_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] mem_data;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic        exc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0, n_err = 0;
   int          cyc = 0, stall_cnt = 0, req_cycles = 0, hs_cnt = 0, exp_hs = 0;
   int          fixed_lat = 0, present_cyc = 0, valid_cyc = 0, hs_cyc = 0;
   logic [31:0] ref_mem   [int unsigned];
   logic [31:0] cache_mem [int unsigned];
   logic [31:0] cur_alu, cur_sd;
   logic        cur_wr, cur_by;
   logic [31:0] last_mem, last_alu, last_hs_wdata, last_hs_addr;
   logic [4:0]  last_rd;
   logic        last_rw, last_exc, last_hs_we, last_hs_byte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input int unsigned wa);
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] ref_rd(input int unsigned wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] cache_rd(input int unsigned wa);
      return cache_mem.exists(wa) ? cache_mem[wa] : init_word(wa);
   endfunction

   task automatic poke(input logic [31:0] addr, input logic [31:0] data);
      ref_mem[addr >> 2]   = data;
      cache_mem[addr >> 2] = data;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (stall_out) stall_cnt++;

   // Cache responder: ready after a chosen number of request cycles, memory behind it.
   always @(negedge clk) begin : responder
      int          req_cnt;
      int          lat;
      int unsigned wa;
      int          lane;
      logic [31:0] w;
      dc_ready_in = 1'b0;
      dc_rdata_in = $urandom();
      if (rst_n && dc_req_out) begin
         req_cnt++;
         req_cycles++;
         if (req_cnt == 1) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
         check("dc_addr", dc_addr_out, cur_alu);
         check("dc_we", 32'(dc_we_out), 32'(cur_wr));
         check("dc_byte", 32'(dc_byte_out), 32'(cur_by));
         if (cur_wr) check("dc_wdata", dc_wdata_out, cur_by ? {4{cur_sd[7:0]}} : cur_sd);
         if (req_cnt >= lat) begin
            dc_ready_in = 1'b1;
            wa   = dc_addr_out >> 2;
            lane = int'(dc_addr_out[1:0]);
            if (dc_we_out) begin
               w = cache_rd(wa);
               if (dc_byte_out) w[8*lane +: 8] = dc_wdata_out[8*lane +: 8];
               else             w = dc_wdata_out;
               cache_mem[wa] = w;
            end else begin
               dc_rdata_in = cache_rd(wa);
            end
            hs_cnt++;
            hs_cyc        = cyc;
            last_hs_wdata = dc_wdata_out;
            last_hs_addr  = dc_addr_out;
            last_hs_we    = dc_we_out;
            last_hs_byte  = dc_byte_out;
            req_cnt       = 0;
         end
      end else begin
         req_cnt     = 0;
         dc_ready_in = 1'($urandom_range(0, 1));
      end
   end

   // Compare process: every completion must match the next expected transaction.
   always @(negedge clk) begin : compare
      exp_t e;
      if (rst_n) begin
         if (valid_out) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 32'(valid_out), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("alu_result_out", alu_result_out, e.alu);
               check("mem_data_out", mem_data_out, e.mem_data);
               check("rd_out", 32'(destination_register_out), 32'(e.rd));
               check("reg_write_out", 32'(cu_reg_write_out), 32'(e.rw));
               check("mem_to_reg_out", 32'(cu_mem_to_reg_out), 32'(e.m2r));
               check("exc_out", 32'(exc_misaligned_out), 32'(e.exc));
               last_mem  = mem_data_out;
               last_alu  = alu_result_out;
               last_rd   = destination_register_out;
               last_rw   = cu_reg_write_out;
               last_exc  = exc_misaligned_out;
               valid_cyc = cyc;
            end
         end else begin
            check("idle_reg_write", 32'(cu_reg_write_out), 32'd0);
            check("idle_exc", 32'(exc_misaligned_out), 32'd0);
         end
      end
   end

   // Presents one instruction, predicts its result, and holds it until accepted.
   task automatic send(input bit rd_op, input bit wr_op, input bit by, input logic [31:0] alu,
                       input logic [31:0] sd, input bit m2r, input bit rw, input logic [4:0] rdi);
      exp_t        e;
      bit          trap;
      int unsigned wa;
      int          lane;
      logic [31:0] w;
      int          n;
      e.alu = alu; e.rd = rdi; e.m2r = m2r; e.rw = rw; e.exc = 1'b0; e.mem_data = '0;
      trap = TRAP_EN && (rd_op || wr_op) && !by && (alu[1:0] != 2'd0);
      wa   = alu >> 2;
      lane = int'(alu[1:0]);
      if (trap) begin
         e.exc = 1'b1;
         e.rw  = 1'b0;
      end else if (wr_op) begin
         w = ref_rd(wa);
         if (by) w[8*lane +: 8] = sd[7:0];
         else    w = sd;
         ref_mem[wa] = w;
         exp_hs++;
      end else if (rd_op) begin
         w = ref_rd(wa);
         if (by) e.mem_data = {{24{w[8*lane+7]}}, w[8*lane +: 8]};
         else    e.mem_data = w;
         exp_hs++;
      end
      exp_q.push_back(e);
      cur_alu = alu; cur_sd = sd; cur_wr = wr_op; cur_by = by;
      valid_in = 1'b1; cu_mem_read_in = rd_op; cu_mem_write_in = wr_op; cu_byte_in = by;
      alu_result_in = alu; store_data_in = sd; cu_mem_to_reg_in = m2r;
      cu_reg_write_in = rw; destination_register_in = rdi;
      present_cyc = cyc;
      n = 0;
      @(negedge clk);
      while (stall_out && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (stall_out) check("accept_timeout", 32'(stall_out), 32'd0);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic idle(input int k);
      valid_in = 1'b0;
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0, r0, n;
      bit r, w;
      int kind;
      rst_n = 1'b0; valid_in = 1'b0; cu_mem_read_in = 1'b0; cu_mem_write_in = 1'b0;
      cu_byte_in = 1'b0; alu_result_in = '0; store_data_in = '0; cu_mem_to_reg_in = 1'b0;
      cu_reg_write_in = 1'b0; destination_register_in = '0;
      cur_alu = '0; cur_sd = '0; cur_wr = 1'b0; cur_by = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_dc_req", 32'(dc_req_out), 32'd0);
      check("rst_stall", 32'(stall_out), 32'd0);
      check("rst_reg_write", 32'(cu_reg_write_out), 32'd0);
      check("rst_exc", 32'(exc_misaligned_out), 32'd0);
      check("rst_mem_data", mem_data_out, 32'd0);
      check("rst_alu_out", alu_result_out, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Non-memory op: one-cycle latency, never stalls.
      s0 = stall_cnt;
      send(1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
      drain();
      check("nonmem_alu", last_alu, 32'h1234);
      check("nonmem_rd", 32'(last_rd), 32'd5);
      check("nonmem_rw", 32'(last_rw), 32'd1);
      check("nonmem_latency", 32'(valid_cyc - present_cyc), 32'd1);
      check("nonmem_stall", 32'(stall_cnt - s0), 32'd0);

      // Word load with ready in the fourth request cycle.
      poke(32'h100, 32'hDEAD_BEEF);
      fixed_lat = 4;
      s0 = stall_cnt; r0 = req_cycles;
      send(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd7);
      drain();
      check("wload_data", last_mem, 32'hDEAD_BEEF);
      check("wload_stall_cycles", 32'(stall_cnt - s0), 32'd5);
      check("wload_req_cycles", 32'(req_cycles - r0), 32'd4);
      check("wload_latency", 32'(valid_cyc - present_cyc), 32'd5);
      fixed_lat = 1;
      send(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd7);
      drain();
      check("wload_min_latency", 32'(valid_cyc - present_cyc), 32'd2);

      // Byte loads: sign-extended high lane, zero-extended-positive low lane.
      poke(32'h100, 32'h80FF_0011);
      fixed_lat = 2;
      send(1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 1'b1, 1'b1, 5'd8);
      drain();
      check("bload_lane3", last_mem, 32'hFFFF_FF80);
      send(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 1'b1, 5'd9);
      drain();
      check("bload_lane0", last_mem, 32'h0000_0011);

      // Byte store: replicated data, completion one cycle after ready.
      send(1'b0, 1'b1, 1'b1, 32'h202, 32'h0000_00AB, 1'b0, 1'b0, 5'd0);
      drain();
      check("bstore_wdata", last_hs_wdata, 32'hABAB_ABAB);
      check("bstore_we", 32'(last_hs_we), 32'd1);
      check("bstore_byte", 32'(last_hs_byte), 32'd1);
      check("bstore_addr", last_hs_addr, 32'h202);
      check("bstore_done_after_ready", 32'(valid_cyc - hs_cyc), 32'd1);
      check("bstore_mem_data", last_mem, 32'd0);
      send(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 5'd3);
      drain();

      // Read and write both set behaves as a store.
      send(1'b1, 1'b1, 1'b0, 32'h208, 32'h1122_3344, 1'b0, 1'b0, 5'd0);
      drain();
      check("rw_both_we", 32'(last_hs_we), 32'd1);

      // Reset while a load is waiting on the cache.
      poke(32'h300, 32'h1357_9BDF);
      fixed_lat = 1000;
      cur_alu = 32'h300; cur_sd = '0; cur_wr = 1'b0; cur_by = 1'b0;
      valid_in = 1'b1; cu_mem_read_in = 1'b1; cu_mem_write_in = 1'b0; cu_byte_in = 1'b0;
      alu_result_in = 32'h300; cu_mem_to_reg_in = 1'b1; cu_reg_write_in = 1'b1;
      destination_register_in = 5'd4;
      n = 0;
      @(negedge clk);
      while (!dc_req_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rstmid_req_seen", 32'(dc_req_out), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_dc_req", 32'(dc_req_out), 32'd0);
      check("rstmid_stall", 32'(stall_out), 32'd0);
      check("rstmid_valid", 32'(valid_out), 32'd0);
      @(posedge clk); #1;
      valid_in = 1'b0;
      exp_q.delete();
      rst_n = 1'b1;
      fixed_lat = 0;
      idle(1);
      send(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 5'd4);
      drain();
      check("rstmid_reload", last_mem, 32'h1357_9BDF);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      r0 = req_cycles;
      send(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 5'd6);
      drain();
      check("trap_no_req", 32'(req_cycles - r0), 32'd0);
      check("trap_exc", 32'(last_exc), 32'd1);
      check("trap_reg_write", 32'(last_rw), 32'd0);
`endif

      // Randomized mix against the reference model.
      for (int i = 0; i < 250; i++) begin
         kind = int'($urandom_range(0, 19));
         r = (kind >= 7 && kind <= 13) || kind == 19;
         w = (kind >= 14);
         if (r || w)
            send(r, w, 1'($urandom_range(0, 1)), 32'h400 + $urandom_range(0, 63), $urandom(),
                 r & ~w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         else
            send(1'b0, 1'b0, 1'b0, $urandom(), $urandom(), 1'b0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      drain();
      check("handshake_count", 32'(hs_cnt), 32'(exp_hs));
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
